// File: rtl/tl_pkg.sv
// Shared types for the traffic-light sensor conditioning slice: light colours,
// lane indices and the per-lane request FSM states.
package tl_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        LANE_NS      = 2'd0,
        LANE_EW_STR  = 2'd1,
        LANE_EW_LEFT = 2'd2
    } lane_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_REQ   = 2'd2,
        ST_SERVE = 2'd3
    } lane_state_e;

    // Light code 3 is not a legal colour and counts as red.
    function automatic logic is_green(input logic [1:0] light);
        return light == GREEN;
    endfunction

endpackage

// File: rtl/sensor_lane.sv
// One lane of the sensor conditioner: synchronizer, debounce/request FSM and
// optional starvation monitor (enabled by defining STARVE_MON_EN).
module sensor_lane
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3,
    parameter int MIN_SERVE    = 2,
    parameter int MAX_WAIT     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw,
    input  logic [1:0] light,
    output logic       sensor,
    output logic       starve
);

    localparam int QW = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = (MIN_SERVE < 1) ? 1 : $clog2(MIN_SERVE + 1);
    localparam logic [QW-1:0] QM1  = QW'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
    localparam logic [SW-1:0] SMAX = SW'(MIN_SERVE);

    logic [1:0]    sync_q;
    logic          raw_s;
    lane_state_e   state, state_nx;
    logic [QW-1:0] qual_cnt, qual_nx;
    logic [SW-1:0] svc_cnt, svc_nx;
    logic          sensor_nx;

    assign raw_s = sync_q[1];

    always_comb begin
        state_nx = state;
        qual_nx  = qual_cnt;
        svc_nx   = svc_cnt;
        case (state)
            ST_IDLE: begin
                if (raw_s) begin
                    if (DEBOUNCE_CYC <= 1) begin
                        state_nx = ST_REQ;
                        qual_nx  = '0;
                    end else begin
                        state_nx = ST_QUAL;
                        qual_nx  = QW'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (!raw_s) begin
                    state_nx = ST_IDLE;
                    qual_nx  = '0;
                end else if (qual_cnt >= QM1) begin
                    state_nx = ST_REQ;
                    qual_nx  = '0;
                end else begin
                    qual_nx = qual_cnt + 1'b1;
                end
            end
            ST_REQ: begin
                if (is_green(light)) begin
                    state_nx = ST_SERVE;
                    svc_nx   = '0;
                end
            end
            ST_SERVE: begin
                if (!is_green(light)) begin
                    state_nx = raw_s ? ST_REQ : ST_IDLE;
                    svc_nx   = '0;
                end else if (svc_cnt < SMAX) begin
                    svc_nx = svc_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                qual_nx  = '0;
                svc_nx   = '0;
            end
        endcase
        // Sensor is registered from next-state so it lines up with the FSM.
        sensor_nx = (state_nx == ST_REQ) ||
                    ((state_nx == ST_SERVE) && (raw_s || (svc_nx < SMAX)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state    <= ST_IDLE;
            qual_cnt <= '0;
            svc_cnt  <= '0;
            sensor   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            state    <= state_nx;
            qual_cnt <= qual_nx;
            svc_cnt  <= svc_nx;
            sensor   <= sensor_nx;
        end
    end

`ifdef STARVE_MON_EN
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WM1  = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else if (state == ST_REQ && state_nx == ST_REQ) begin
            if (wait_cnt < WMAX) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WM1) starve <= 1'b1;
        end else begin
            wait_cnt <= '0;
            if (state_nx == ST_SERVE) starve <= 1'b0;
        end
    end
`else
    // MAX_WAIT is non-negative, so this is a constant 0 with no wait logic.
    assign starve = (MAX_WAIT < 0);
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Three-lane vehicle detector conditioner feeding traffic_light_controller;
// define STARVE_MON_EN to build the per-lane starvation monitors.
module sensor_conditioner
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3,
    parameter int MIN_SERVE    = 2,
    parameter int MAX_WAIT     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_ew_left,
    input  logic       raw_ew_str,
    input  logic       raw_ns,
    input  logic [1:0] ew_left_light,
    input  logic [1:0] ew_str_light,
    input  logic [1:0] ns_light,
    output logic       ew_left_sensor,
    output logic       ew_str_sensor,
    output logic       ns_sensor,
    output logic [2:0] starve
);

    sensor_lane #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .MIN_SERVE(MIN_SERVE), .MAX_WAIT(MAX_WAIT)
    ) u_ew_left (
        .clk(clk), .reset_n(reset_n), .raw(raw_ew_left), .light(ew_left_light),
        .sensor(ew_left_sensor), .starve(starve[LANE_EW_LEFT])
    );

    sensor_lane #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .MIN_SERVE(MIN_SERVE), .MAX_WAIT(MAX_WAIT)
    ) u_ew_str (
        .clk(clk), .reset_n(reset_n), .raw(raw_ew_str), .light(ew_str_light),
        .sensor(ew_str_sensor), .starve(starve[LANE_EW_STR])
    );

    sensor_lane #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .MIN_SERVE(MIN_SERVE), .MAX_WAIT(MAX_WAIT)
    ) u_ns (
        .clk(clk), .reset_n(reset_n), .raw(raw_ns), .light(ns_light),
        .sensor(ns_sensor), .starve(starve[LANE_NS])
    );

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 3: consecutive synchronized-high cycles needed to qualify a detection.
REQ-002 SHALL have parameter MIN_SERVE, default 2: minimum green cycles the request is held after service begins.
REQ-003 SHALL have parameter MAX_WAIT, default 20: request cycles before the starvation flag is raised.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 raw_ew_left, raw_ew_str, raw_ns  input  1 each  asynchronous vehicle detector levels.
REQ-007 ew_left_light, ew_str_light, ns_light  input  2 each  controller light feedback; red=0, yellow=1, green=2, 3 treated as red.
REQ-008 ew_left_sensor, ew_str_sensor, ns_sensor  output  1 each  qualified requests driving the traffic_light_controller sensor inputs.
REQ-009 starve  output  3  per-lane starvation flags: bit2 ew_left, bit1 ew_str, bit0 ns.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each lane SHALL run an independent FSM with states IDLE, QUAL, REQ, SERVE.
REQ-012 IDLE: sensor=0; synced raw=1 -> QUAL with qual count=1.
REQ-013 QUAL: sensor=0; synced raw=0 -> IDLE; count reaching DEBOUNCE_CYC -> REQ.
REQ-014 REQ: sensor=1; lane light==green -> SERVE with service count cleared; synced raw dropping does NOT cancel the request.
REQ-015 SERVE: sensor = synced raw OR (service count < MIN_SERVE); service count saturates.
REQ-016 SERVE exit: when lane light != green -> REQ if synced raw=1, else IDLE.
REQ-017 Sensor outputs SHALL be registered; with raw held high, sensor rises exactly 2+DEBOUNCE_CYC rising edges after the first edge sampling raw high.
REQ-018 A raw glitch shorter than DEBOUNCE_CYC synchronized cycles SHALL never assert the sensor.
REQ-019 Lanes SHALL not interact; simultaneous detections on all lanes qualify on the same cycle.
REQ-020 A light that becomes green in QUAL or IDLE SHALL be ignored (no SERVE entry).
REQ-021 All counters SHALL be sized by $clog2 of their limit and saturate; no wrap-around.

Reset
REQ-022 reset_n low SHALL immediately force all FSMs to IDLE, all counters and synchronizer flops to 0, sensors=0, starve=0.
REQ-023 Reset asserted mid-request SHALL drop the request; a raw input held across reset release requalifies per REQ-017.

Configuration
REQ-024 Macro STARVE_MON_EN defined: per-lane wait counter increments in REQ; starve bit sets when count reaches MAX_WAIT, stays set until the lane enters SERVE or reset.
REQ-025 STARVE_MON_EN undefined: no wait counters synthesized; starve port present and tied to 0.

Structure
REQ-026 Shared package tl_pkg SHALL hold the color enum {red,yellow,green}, the lane-index enum, and the per-lane FSM state enum.
REQ-027 Per-lane logic SHALL be one sub-module sensor_lane, instantiated three times by sensor_conditioner.

Verification
REQ-028 raw_ns=1 held, lights red -> ns_sensor=1 exactly 5 edges later, others stay 0.
REQ-029 raw_ew_str pulse of 2 cycles -> ew_str_sensor never asserts.
REQ-030 ew_str qualified, raw dropped, ew_str_light=green 1 cycle later -> sensor held 1 for 2 green cycles then 0; light red -> FSM IDLE.
REQ-031 All three raw high at once -> all three sensors rise on the same edge; ns_light green, then yellow with raw_ns still high -> ns returns to REQ, ns_sensor stays 1.
REQ-032 With STARVE_MON_EN: ew_left in REQ 20 cycles, light red -> starve=3'b100; light green -> starve clears next edge. Without the macro, starve stays 0.
REQ-033 reset_n low for 1 cycle while ew_left in SERVE -> all outputs 0 immediately; raw still high -> ew_left_sensor reasserts 5 edges after release.
